// File: rtl/param_sum_pkg.sv
// Shared types and defaults for the parameterised sum accumulator.
package param_sum_pkg;

    typedef enum logic [1:0] {IDLE, ACC, DONE} acc_state_e;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/param_sum_step.sv
// One accumulation step: {carry, next} = cur + in + BIAS, evaluated at WIDTH+1 bits.
// BIAS is zero-extended or truncated to WIDTH before the add.
module param_sum_step #(
    parameter int          WIDTH = 32,
    parameter int unsigned BIAS  = 0
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] next,
    output logic             carry
);

    localparam logic [WIDTH-1:0] BIAS_W = WIDTH'(BIAS);

    logic [WIDTH:0] total;

    // Only the low WIDTH+1 bits are kept; bit WIDTH is the carry-out.
    always_comb begin
        total = {1'b0, cur} + {1'b0, in} + {1'b0, BIAS_W};
    end

    assign {carry, next} = total;

endmodule

// File: rtl/param_sum_accumulator.sv
// Accumulates operand (+ a constant bias) over N_ACC cycles after a start
// pulse, then holds the result on a valid/ready output until accepted.
module param_sum_accumulator
    import param_sum_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int N_ACC  = 4,
    parameter int BIAS_A = 0,
    parameter int BIAS_B = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             overflow,
    output logic             busy
);

    localparam int            CW   = $clog2(N_ACC + 1);
    localparam logic [CW-1:0] LAST = CW'(N_ACC - 1);

    acc_state_e       state, state_nx;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sum_nx;
    logic             carry;

    // Bias is folded at instantiation so each parameter set gets its own step.
    param_sum_step #(
        .WIDTH (WIDTH),
        .BIAS  (BIAS_A + BIAS_B)
    ) u_step (
        .cur   (sum),
        .in    (operand),
        .next  (sum_nx),
        .carry (carry)
    );

    // State register; reset abandons any run in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state: start only honoured in IDLE; leave ACC on the final add.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ACC;
            ACC:     if (count == LAST) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: clear on accepted start, add every ACC cycle, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sum      <= '0;
                    count    <= '0;
                    overflow <= 1'b0;
                end
                ACC: begin
                    sum      <= sum_nx;
                    overflow <= overflow | carry;
                    count    <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decode straight from state.
    always_comb begin
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_param_sum_accumulator.sv
// Directed bench: default-parameter accumulator plus a biased (1+2) instance.
module tb_param_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start_b;
    logic [31:0] operand;
    logic [31:0] operand_b;
    logic        out_ready;
    logic        out_valid, overflow, busy;
    logic [31:0] sum;
    logic        out_valid_b, overflow_b, busy_b;
    logic [31:0] sum_b;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    param_sum_accumulator u_dut (
        .clk(clk), .rst(rst), .start(start), .operand(operand),
        .out_ready(out_ready), .out_valid(out_valid), .sum(sum),
        .overflow(overflow), .busy(busy)
    );

    param_sum_accumulator #(.BIAS_A(1), .BIAS_B(2)) u_bias (
        .clk(clk), .rst(rst), .start(start_b), .operand(operand_b),
        .out_ready(1'b1), .out_valid(out_valid_b), .sum(sum_b),
        .overflow(overflow_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; inputs are driven and outputs sampled here.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then run the remaining adds.
    task automatic run_to_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        repeat (3) tick();
        chk("valid_before_last_add", 32'(out_valid), 32'd0);
        tick();
        chk("valid_after_last_add", 32'(out_valid), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_b = 1'b0;
        operand = '0; operand_b = '0; out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic run: 4 x 3 = 12, then back to idle on the accepting edge.
        operand = 32'd3;
        run_to_done();
        chk("basic_sum", sum, 32'd12);
        chk("basic_ovf", 32'(overflow), 32'd0);
        tick();
        chk("basic_idle", 32'(busy), 32'd0);
        chk("basic_sum_kept", sum, 32'd12);

        // Backpressure with stray starts while DONE.
        out_ready = 1'b0;
        run_to_done();
        for (int i = 0; i < 5; i++) begin
            start = (i == 1 || i == 3);
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", sum, 32'd12);
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_idle", 32'(busy), 32'd0);
        tick();
        chk("bp_no_queued_run", 32'(busy), 32'd0);

        // Carry chain: overflow first appears on add 2 and sticks.
        operand = 32'hC000_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ovf_add1", 32'(overflow), 32'd0);
        tick();
        chk("ovf_add2", 32'(overflow), 32'd1);
        chk("ovf_add2_sum", sum, 32'h8000_0000);
        repeat (2) tick();
        chk("ovf_valid", 32'(out_valid), 32'd1);
        chk("ovf_sum", sum, 32'h0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        tick();
        operand = 32'd1;
        run_to_done();
        chk("ovf_cleared_sum", sum, 32'd4);
        chk("ovf_cleared_flag", 32'(overflow), 32'd0);
        tick();

        // Bias instance: operand 0, bias 3, four adds.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        repeat (4) tick();
        chk("bias_valid", 32'(out_valid_b), 32'd1);
        chk("bias_sum", sum_b, 32'd12);
        tick();

        // Reset after two adds: asynchronous clear, no valid afterwards.
        operand = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("mid_partial_sum", sum, 32'd6);
        rst = 1'b1;
        #1;
        chk("mid_rst_sum", sum, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_valid", 32'(out_valid), 32'd0);
        end
        run_to_done();
        chk("mid_fresh_sum", sum, 32'd12);
        tick();

        // Reset under random activity.
        for (int i = 0; i < 3; i++) begin
            operand   = $urandom;
            start     = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b1;
        tick();
        operand = $urandom;
        tick();
        rst = 1'b1;
        #1;
        chk("rnd_rst_valid", 32'(out_valid), 32'd0);
        chk("rnd_rst_sum", sum, 32'd0);
        chk("rnd_rst_ovf", 32'(overflow), 32'd0);
        chk("rnd_rst_busy", 32'(busy), 32'd0);
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("rnd_post_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
